fifo_ctrl: RTL and testbench

8-entry, 32-bit FIFO control stage that sits directly upstream of the FIFO read multiplexer. It owns head/tail pointers, occupancy count and the handshake state machine. It drives the register-file write enables and the mux `sel`/`re` inputs, and registers the mux output onto the FIFO read-data port. It is the sequential core of the FIFO top level; the register file and the 8-to-1 read mux stay as they are.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_wr_decoder.sv | 17 +
 rtl/fifo_ctrl.sv | 94 +++++++++
 tb/tb_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 8-entry FIFO control stage.
package fifo_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_wr_decoder.sv
// 3-to-8 one-hot decoder with enable; drives the register-file write enables.
module fifo_wr_decoder
  import fifo_pkg::*;
(
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  output logic [DEPTH-1:0] o_we
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign o_we[gi] = i_en && (i_addr == AW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: pointers, occupancy, handshake FSM and registered read data.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DW-1:0]    mux_dout,
  output logic [DEPTH-1:0] we,
  output logic [AW-1:0]    rd_sel,
  output logic             rd_re,
  output logic [DW-1:0]    d_out,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [AW:0]      data_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_d_out;
  logic          w_wr_go;
  logic          w_rd_go;

  always_comb begin
    w_state_next = NO_OP;
    w_wr_go      = 1'b0;
    w_rd_go      = 1'b0;
    if (wr_en && !rd_en) begin
      if (r_count != FULL_COUNT) begin
        w_state_next = WRITE;
        w_wr_go      = 1'b1;
      end else begin
        w_state_next = WR_ERROR;
      end
    end else if (rd_en && !wr_en) begin
      if (r_count != '0) begin
        w_state_next = READ;
        w_rd_go      = 1'b1;
      end else begin
        w_state_next = RD_ERROR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_d_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_go) begin
        r_tail  <= r_tail + AW'(1);
        r_count <= r_count + (AW+1)'(1);
      end
      if (w_rd_go) begin
        r_head  <= r_head + AW'(1);
        r_count <= r_count - (AW+1)'(1);
        r_d_out <= mux_dout;
      end
    end
  end

  // Request-cycle strobes are masked while reset is held so the register file stays untouched.
  fifo_wr_decoder u_wr_decoder (
    .i_en   (w_wr_go && !rst),
    .i_addr (r_tail),
    .o_we   (we)
  );

  assign rd_re      = w_rd_go && !rst;
  assign rd_sel     = r_head;
  assign d_out      = r_d_out;
  assign full       = (r_count == FULL_COUNT);
  assign empty      = (r_count == '0);
  assign data_count = r_count;
  assign wr_ack     = (r_state == WRITE);
  assign wr_err     = (r_state == WR_ERROR);
  assign rd_ack     = (r_state == READ);
  assign rd_err     = (r_state == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a local register file and read mux.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [DW-1:0]    mux_dout;
  logic [DEPTH-1:0] we;
  logic [AW-1:0]    rd_sel;
  logic             rd_re;
  logic [DW-1:0]    d_out;
  logic             full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [AW:0]      data_count;

  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rf [DEPTH];

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of stored words plus total write/read counts.
  logic [DW-1:0] q [$];
  int unsigned   wr_total;
  int unsigned   rd_total;
  logic [DW-1:0] m_dout;
  logic [DEPTH-1:0] we_seen;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] data;
    logic [7:0]  e_we;
    bit          e_wr_ack;
    bit          e_wr_err;
    bit          e_rd_ack;
    bit          e_rd_err;
    bit          e_full;
    bit          e_empty;
    logic [3:0]  e_cnt;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .mux_dout   (mux_dout),
    .we         (we),
    .rd_sel     (rd_sel),
    .rd_re      (rd_re),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) rf[i] <= wdata;
    end
  end

  assign mux_dout = rf[rd_sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    m_dout   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},     32'(we), 32'h0);
    chk({tag, "_rd_re"},  32'(rd_re), 32'h0);
    chk({tag, "_empty"},  32'(empty), 32'h1);
    chk({tag, "_full"},   32'(full), 32'h0);
    chk({tag, "_acks"},   {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
    chk({tag, "_count"},  32'(data_count), 32'h0);
    chk({tag, "_dout"},   d_out, 32'h0);
  endtask

  // One cycle: drive at posedge+1, check strobes, clock, check registered outputs.
  task automatic step(input bit wr, input bit rd, input logic [31:0] data);
    bit acc_w, err_w, acc_r, err_r;
    logic [7:0] exp_we;
    int sz;
    sz    = q.size();
    acc_w = wr && !rd && (sz < DEPTH);
    err_w = wr && !rd && (sz == DEPTH);
    acc_r = rd && !wr && (sz > 0);
    err_r = rd && !wr && (sz == 0);
    exp_we = acc_w ? 8'(1 << (wr_total % DEPTH)) : 8'h0;
    wr_en = wr;
    rd_en = rd;
    wdata = data;
    #1;
    we_seen = we;
    chk("we", 32'(we), 32'(exp_we));
    chk("rd_re", 32'(rd_re), 32'(acc_r));
    chk("rd_sel", 32'(rd_sel), rd_total % DEPTH);
    @(posedge clk);
    #1;
    if (acc_w) begin
      q.push_back(data);
      wr_total++;
    end
    if (acc_r) begin
      m_dout = q.pop_front();
      rd_total++;
    end
    $display("step wr=%0d rd=%0d data=0x%08h -> count=%0d d_out=0x%08h ack=%0d%0d err=%0d%0d",
             wr, rd, data, data_count, d_out, wr_ack, rd_ack, wr_err, rd_err);
    chk("d_out", d_out, m_dout);
    chk("wr_ack", 32'(wr_ack), 32'(acc_w));
    chk("wr_err", 32'(wr_err), 32'(err_w));
    chk("rd_ack", 32'(rd_ack), 32'(acc_r));
    chk("rd_err", 32'(rd_err), 32'(err_r));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("data_count", 32'(data_count), q.size());
  endtask

  initial begin
    // Directed fill/drain table: 8 writes, overflow, 8 reads, underflow.
    for (int i = 0; i < 18; i++) begin
      tbl[i] = '{wr:0, rd:0, data:32'h0, e_we:8'h0, e_wr_ack:0, e_wr_err:0, e_rd_ack:0,
                 e_rd_err:0, e_full:0, e_empty:0, e_cnt:4'd0, e_dout:32'h0};
    end
    for (int i = 0; i < 8; i++) begin
      tbl[i].wr       = 1;
      tbl[i].data     = 32'h11111111 * (i + 1);
      tbl[i].e_we     = 8'(1 << i);
      tbl[i].e_wr_ack = 1;
      tbl[i].e_full   = (i == 7);
      tbl[i].e_cnt    = 4'(i + 1);
    end
    tbl[8].wr       = 1;
    tbl[8].data     = 32'hDEADBEEF;
    tbl[8].e_wr_err = 1;
    tbl[8].e_full   = 1;
    tbl[8].e_cnt    = 4'd8;
    for (int i = 0; i < 8; i++) begin
      tbl[9+i].rd       = 1;
      tbl[9+i].e_rd_ack = 1;
      tbl[9+i].e_cnt    = 4'(7 - i);
      tbl[9+i].e_empty  = (i == 7);
      tbl[9+i].e_full   = 0;
      tbl[9+i].e_dout   = 32'h11111111 * (i + 1);
    end
    tbl[17].rd       = 1;
    tbl[17].e_rd_err = 1;
    tbl[17].e_empty  = 1;
    tbl[17].e_dout   = 32'h88888888;

    for (int i = 0; i < DEPTH; i++) rf[i] = '0;
    wr_en = 0;
    rd_en = 0;
    wdata = '0;
    rst   = 1;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // Idle cycle after release.
    step(0, 0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].data);
      chk("tbl_we", 32'(we_seen), 32'(tbl[i].e_we));
      chk("tbl_flags", {26'h0, wr_ack, wr_err, rd_ack, rd_err, full, empty},
          {26'h0, tbl[i].e_wr_ack, tbl[i].e_wr_err, tbl[i].e_rd_ack, tbl[i].e_rd_err,
           tbl[i].e_full, tbl[i].e_empty});
      chk("tbl_count", 32'(data_count), 32'(tbl[i].e_cnt));
      chk("tbl_dout", d_out, tbl[i].e_dout);
    end

    // Wrap-around: write 5, read 5, write 6, read 6.
    for (int i = 0; i < 5; i++) step(1, 0, 32'hA0000000 + i);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'hB0000000 + i);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h0);
      chk("wrap_dout", d_out, 32'hB0000000 + i);
    end
    chk("wrap_count", 32'(data_count), 32'h0);

    // Simultaneous requests with 3 entries: no-op.
    for (int i = 0; i < 3; i++) step(1, 0, 32'hC0000000 + i);
    step(1, 1, 32'hCCCCCCCC);
    chk("both_acks", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
    chk("both_count", 32'(data_count), 32'h3);

    // Reset mid-burst with 4 entries, write request still asserted.
    step(1, 0, 32'hC0000003);
    chk("pre_rst_count", 32'(data_count), 32'h4);
    wr_en = 1;
    rd_en = 0;
    rst   = 1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst   = 0;
    wr_en = 0;
    step(0, 1, 32'h0);
    chk("post_rst_rd_err", 32'(rd_err), 32'h1);

    // Randomised traffic, biased in phases to reach full and empty often.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      bit w, rr;
      r  = $urandom_range(0, 9);
      if ((i / 60) % 2 == 0) begin
        w  = (r < 6);
        rr = (r >= 5);
      end else begin
        w  = (r >= 6);
        rr = (r < 5);
      end
      step(w, rr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
